dcache_wt_direct: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per line. It sits between the core's load/store stage and the word-addressed simulation memory's data port. It turns CPU loads and stores into single-outstanding memory transactions and holds the core with cpu_stall on misses and stores. It also keeps hit and miss counters for the benches.

---
 rtl/dcache_wt_direct_if.sv | 34 +++
 rtl/dcache_wt_direct.sv | 128 ++++++++++++
 tb/tb_dcache_wt_direct.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_wt_direct_if.sv
// CPU-side and memory-side signal bundle of the write-through data cache.
// The slave modport is the cache's view; master is the core/memory environment.
interface dcache_wt_direct_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ren;
  logic              cpu_wen;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_bsel;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ren;
  logic              mem_wen;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_bsel;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  modport slave (
    input  cpu_addr, cpu_ren, cpu_wen, cpu_wdata, cpu_bsel, mem_rdata, mem_ready,
    output cpu_rdata, cpu_stall, mem_addr, mem_ren, mem_wen, mem_wdata, mem_bsel,
           hit_count, miss_count
  );

  modport master (
    output cpu_addr, cpu_ren, cpu_wen, cpu_wdata, cpu_bsel, mem_rdata, mem_ready,
    input  cpu_rdata, cpu_stall, mem_addr, mem_ren, mem_wen, mem_wdata, mem_bsel,
           hit_count, miss_count
  );
endinterface

// File: rtl/dcache_wt_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line,
// with a single outstanding memory transaction and load hit/miss counters.
module dcache_wt_direct #(
  parameter int ADDR_W     = 16,
  parameter int INDEX_BITS = 6
) (
  input  logic               clk,
  input  logic               reset,
  dcache_wt_direct_if.slave  bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

  state_t                  state;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_arr  [LINES];
  logic [31:0]             data_arr [LINES];

  logic [INDEX_BITS-1:0]   idx;
  logic [TAG_W-1:0]        tag;
  logic [INDEX_BITS-1:0]   fill_idx;
  logic [TAG_W-1:0]        fill_tag;
  logic                    hit;
  logic                    fill;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  bsel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = bsel[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    return res;
  endfunction

  assign idx      = bus.cpu_addr[INDEX_BITS-1:0];
  assign tag      = bus.cpu_addr[ADDR_W-1:INDEX_BITS];
  // The miss address stays latched in mem_addr, so the fill never depends on the core holding cpu_addr.
  assign fill_idx = bus.mem_addr[INDEX_BITS-1:0];
  assign fill_tag = bus.mem_addr[ADDR_W-1:INDEX_BITS];
  assign hit      = valid[idx] && (tag_arr[idx] == tag);
  assign fill     = (state == RD_WAIT) && bus.mem_ready;

  always_comb begin
    bus.cpu_stall = 1'b0;
    bus.cpu_rdata = 32'd0;
    case (state)
      IDLE: begin
        if (bus.cpu_wen)
          bus.cpu_stall = 1'b1;
        else if (bus.cpu_ren) begin
          bus.cpu_stall = !hit;
          if (hit) bus.cpu_rdata = data_arr[idx];
        end
      end
      RD_WAIT: begin
        bus.cpu_stall = !bus.mem_ready;
        if (bus.mem_ready) bus.cpu_rdata = bus.mem_rdata;
      end
      WR_WAIT: bus.cpu_stall = !bus.mem_ready;
      default: bus.cpu_stall = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      valid          <= '0;
      bus.mem_addr   <= '0;
      bus.mem_ren    <= 1'b0;
      bus.mem_wen    <= 1'b0;
      bus.mem_wdata  <= 32'd0;
      bus.mem_bsel   <= 4'd0;
      bus.hit_count  <= 32'd0;
      bus.miss_count <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_wen) begin
            bus.mem_wen   <= 1'b1;
            bus.mem_addr  <= bus.cpu_addr;
            bus.mem_wdata <= bus.cpu_wdata;
            bus.mem_bsel  <= bus.cpu_bsel;
            state         <= WR_REQ;
          end else if (bus.cpu_ren) begin
            if (hit)
              bus.hit_count <= bus.hit_count + 32'd1;
            else begin
              bus.miss_count <= bus.miss_count + 32'd1;
              bus.mem_ren    <= 1'b1;
              bus.mem_addr   <= bus.cpu_addr;
              state          <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          bus.mem_ren <= 1'b0;
          state       <= RD_WAIT;
        end
        RD_WAIT: begin
          if (bus.mem_ready) begin
            valid[fill_idx] <= 1'b1;
            state           <= IDLE;
          end
        end
        WR_REQ: begin
          bus.mem_wen <= 1'b0;
          state       <= WR_WAIT;
        end
        WR_WAIT: begin
          if (bus.mem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; a cleared valid bit hides any stale or half-written line.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= bus.mem_rdata;
    end else if ((state == IDLE) && bus.cpu_wen && hit) begin
      data_arr[idx] <= merge_bytes(data_arr[idx], bus.cpu_wdata, bus.cpu_bsel);
    end
  end
endmodule

// File: tb/tb_dcache_wt_direct.sv
// Scoreboard bench for dcache_wt_direct: stimulus pushes expected completions,
// a negedge monitor pops and compares them; strobes and counters checked inline.
module tb_dcache_wt_direct;
  logic clk;
  logic reset;

  dcache_wt_direct_if #(.ADDR_W(16)) bus ();

  dcache_wt_direct #(.ADDR_W(16), .INDEX_BITS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        is_store;
    logic [31:0] rdata;
    int          stalls;
  } exp_t;

  exp_t sbq[$];
  int checks;
  int failures;
  int mon_stalls;
  logic [31:0] mem [0:65535];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Word-addressed memory: read data registered one cycle after mem_ren.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'hC0DE0000 | i;
    mem[16'h0010] = 32'hDEADBEEF;
    bus.mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_wen)
        for (int b = 0; b < 4; b++)
          if (bus.mem_bsel[b]) mem[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
    end
  end

  // Monitor: counts stall cycles of the current request and checks each completion.
  initial begin
    exp_t e;
    mon_stalls = 0;
    forever begin
      @(negedge clk);
      if (reset)
        mon_stalls = 0;
      else if (bus.cpu_ren || bus.cpu_wen) begin
        if (bus.cpu_stall)
          mon_stalls++;
        else begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_completion actual=addr %h required=no completion", bus.cpu_addr);
          end else begin
            e = sbq.pop_front();
            check("kind_is_store", {31'd0, bus.cpu_wen}, {31'd0, e.is_store});
            check("cpu_rdata", bus.cpu_rdata, e.is_store ? 32'd0 : e.rdata);
            check("stall_cycles", mon_stalls, e.stalls);
          end
          mon_stalls = 0;
        end
      end
    end
  end

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.cpu_stall && n < 40);
    if (bus.cpu_stall) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=stall after %0d cycles required=completion", name, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] a, input logic [31:0] d, input int st);
    sbq.push_back('{is_store: 1'b0, rdata: d, stalls: st});
    bus.cpu_addr = a;
    bus.cpu_ren  = 1'b1;
    bus.cpu_wen  = 1'b0;
    wait_done("load");
    bus.cpu_ren  = 1'b0;
  endtask

  task automatic do_store(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic also_ren, input int hold);
    sbq.push_back('{is_store: 1'b1, rdata: 32'd0, stalls: 2 + hold});
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_bsel  = be;
    bus.cpu_ren   = also_ren;
    bus.cpu_wen   = 1'b1;
    @(posedge clk); #1;
    check("wr_req_mem_wen", {31'd0, bus.mem_wen}, 32'd1);
    check("wr_req_mem_ren", {31'd0, bus.mem_ren}, 32'd0);
    check("wr_req_mem_addr", {16'd0, bus.mem_addr}, {16'd0, a});
    check("wr_req_mem_wdata", bus.mem_wdata, d);
    check("wr_req_mem_bsel", {28'd0, bus.mem_bsel}, {28'd0, be});
    @(posedge clk); #1;
    check("wr_wait_mem_wen", {31'd0, bus.mem_wen}, 32'd0);
    check("wr_wait_mem_ren", {31'd0, bus.mem_ren}, 32'd0);
    if (hold > 0) begin
      bus.mem_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        check("wr_hold_mem_ren", {31'd0, bus.mem_ren}, 32'd0);
      end
      bus.mem_ready = 1'b1;
    end
    wait_done("store");
    bus.cpu_ren = 1'b0;
    bus.cpu_wen = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.cpu_addr  = 16'd0;
    bus.cpu_ren   = 1'b0;
    bus.cpu_wen   = 1'b0;
    bus.cpu_wdata = 32'd0;
    bus.cpu_bsel  = 4'd0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_ren", {31'd0, bus.mem_ren}, 32'd0);
    check("rst_mem_wen", {31'd0, bus.mem_wen}, 32'd0);
    check("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_bsel", {28'd0, bus.mem_bsel}, 32'd0);
    check("rst_hit_count", bus.hit_count, 32'd0);
    check("rst_miss_count", bus.miss_count, 32'd0);
    reset = 1'b0;
    #1;
    check("idle_stall", {31'd0, bus.cpu_stall}, 32'd0);
    check("idle_rdata", bus.cpu_rdata, 32'd0);
    @(posedge clk); #1;

    // Fill line 0x10, then abort a conflicting miss with reset while in RD_REQ.
    do_load(16'h0010, 32'hDEADBEEF, 2);
    bus.cpu_addr = 16'h0050;
    bus.cpu_ren  = 1'b1;
    @(posedge clk); #1;
    check("rd_req_mem_ren", {31'd0, bus.mem_ren}, 32'd1);
    check("rd_req_mem_addr", {16'd0, bus.mem_addr}, 32'h0050);
    #1 reset = 1'b1;
    #1;
    check("abort_mem_ren", {31'd0, bus.mem_ren}, 32'd0);
    check("abort_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    bus.cpu_ren = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("abort_miss_count", bus.miss_count, 32'd0);
    @(posedge clk); #1;

    // Valid bits were cleared: 0x10 misses again, then hits.
    do_load(16'h0010, 32'hDEADBEEF, 2);
    do_load(16'h0010, 32'hDEADBEEF, 0);
    check("t2_hit_count", bus.hit_count, 32'd1);
    check("t2_miss_count", bus.miss_count, 32'd1);

    // Store hit merges low two bytes into the line.
    do_store(16'h0010, 32'h12345678, 4'b0011, 1'b0, 0);
    do_load(16'h0010, 32'hDEAD5678, 0);
    check("t3_hit_count", bus.hit_count, 32'd2);

    // Store miss does not allocate; the load fetches the written word.
    do_store(16'h0020, 32'hCAFEF00D, 4'b1111, 1'b0, 0);
    do_load(16'h0020, 32'hCAFEF00D, 2);
    check("t4_miss_count", bus.miss_count, 32'd2);

    // Same index, different tag: lines evict each other.
    do_load(16'h0005, 32'hC0DE0005, 2);
    do_load(16'h0045, 32'hC0DE0045, 2);
    do_load(16'h0005, 32'hC0DE0005, 2);
    check("t5_miss_count", bus.miss_count, 32'd5);
    check("t5_hit_count", bus.hit_count, 32'd2);

    // Store with no byte enables leaves the cached word untouched.
    do_store(16'h0010, 32'hFFFFFFFF, 4'b0000, 1'b0, 0);
    do_load(16'h0010, 32'hDEAD5678, 0);
    check("bsel0_hit_count", bus.hit_count, 32'd3);

    // ren and wen together is a store; memory held not-ready for 3 cycles.
    do_store(16'h0030, 32'h0BADF00D, 4'b1111, 1'b1, 3);
    check("t6_miss_count", bus.miss_count, 32'd5);
    check("t6_hit_count", bus.hit_count, 32'd3);
    do_load(16'h0030, 32'h0BADF00D, 2);
    check("t6_load_miss_count", bus.miss_count, 32'd6);

    @(negedge clk);
    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
